ps2_cmd_queue: RTL and testbench

- Parametrised successor to the current keyboard front end. It receives raw PS/2 frames and decodes make, break and extended (E0) scancodes into game operation codes.
- Decoded events are buffered in a FIFO. The game core (main) drains them with a valid/ready handshake, so no keystrokes are lost while main is busy in a battle or shop update.
- Sits between the PS/2 pins and main, in place of the single-register operation output.

---
 rtl/ps2_cmd_queue.sv | 259 +++++++++++++++++++++++++
 tb/tb_ps2_cmd_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_cmd_queue
// Description : PS/2 receiver and scancode decoder feeding a valid/ready FIFO
//               of game operation codes. Optional macro PS2_REPEAT_FILTER_EN
//               drops typematic repeats of keys that are already held.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_cmd_queue #(
    parameter int CLK_HZ     = 100000000,
    parameter int FILT_LEN   = 8,
    parameter int TIMEOUT_US = 1000,
    parameter int DEPTH      = 4,
    parameter int OP_W       = 5
) (
    input  logic                     clk_100mhz,
    input  logic                     rst,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic                     op_valid,
    output logic [OP_W-1:0]          op_data,
    output logic                     op_brk,
    input  logic                     op_ready,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int c_AW     = $clog2(DEPTH);
    localparam int c_TO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int c_TO_W   = $clog2(c_TO_CYC + 1);
    localparam int c_FW     = $clog2(FILT_LEN + 1);

    localparam logic [c_FW-1:0]   c_FILT_MAX  = c_FW'(FILT_LEN - 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX    = c_TO_W'(c_TO_CYC - 1);
    localparam logic [c_AW:0]     c_DEPTH_CNT = (c_AW + 1)'(DEPTH);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_EXT     = 2'd1;
    localparam logic [1:0] c_ST_BRK     = 2'd2;
    localparam logic [1:0] c_ST_EXT_BRK = 2'd3;

    // ---------------- synchroniser and clock filter ----------------
    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_filt_clk, r_filt_prev;
    logic [c_FW-1:0] r_filt_cnt;
    logic            w_fall;

    always_ff @(posedge clk_100mhz or negedge rst) begin
        if (!rst) begin
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_filt_clk  <= 1'b1;
            r_filt_prev <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_clk_s1    <= ps2_clk;
            r_clk_s2    <= r_clk_s1;
            r_dat_s1    <= ps2_data;
            r_dat_s2    <= r_dat_s1;
            r_filt_prev <= r_filt_clk;
            // Output flips only after FILT_LEN consecutive samples disagree with it
            if (r_clk_s2 == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FILT_MAX) begin
                r_filt_clk <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + c_FW'(1);
            end
        end
    end

    assign w_fall = r_filt_prev & ~r_filt_clk;

    // ---------------- frame receiver ----------------
    logic [3:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_start_bit, r_par_bit;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_byte_stb, r_frame_err, r_bad_frame;
    logic [7:0]        r_byte;

    always_ff @(posedge clk_100mhz or negedge rst) begin
        if (!rst) begin
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_start_bit <= 1'b0;
            r_par_bit   <= 1'b0;
            r_to_cnt    <= '0;
            r_byte_stb  <= 1'b0;
            r_frame_err <= 1'b0;
            r_bad_frame <= 1'b0;
            r_byte      <= 8'd0;
        end else begin
            r_byte_stb  <= 1'b0;
            r_frame_err <= 1'b0;
            r_bad_frame <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd0) begin
                    r_start_bit <= r_dat_s2;
                    r_bit_cnt   <= 4'd1;
                end else if (r_bit_cnt == 4'd9) begin
                    r_par_bit <= r_dat_s2;
                    r_bit_cnt <= 4'd10;
                end else if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= 4'd0;
                    if (!r_start_bit && r_dat_s2 && (^{r_shift, r_par_bit})) begin
                        r_byte_stb <= 1'b1;
                        r_byte     <= r_shift;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_bad_frame <= 1'b1;
                    end
                end else begin
                    r_shift   <= {r_dat_s2, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == c_TO_MAX) begin
                    r_bit_cnt   <= 4'd0;
                    r_to_cnt    <= '0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + c_TO_W'(1);
                end
            end
        end
    end

    // ---------------- scancode decoder ----------------
    logic [1:0] r_state;
    logic       r_push, r_push_brk;
    logic [2:0] r_push_code;
    logic [2:0] w_code;
    logic       w_is_ext, w_is_brk, w_prefix, w_lookup, w_accept;

    assign w_is_ext = (r_state == c_ST_EXT) || (r_state == c_ST_EXT_BRK);
    assign w_is_brk = (r_state == c_ST_BRK) || (r_state == c_ST_EXT_BRK);
    assign w_prefix = ((r_byte == 8'hE0) && (r_state == c_ST_IDLE)) ||
                      ((r_byte == 8'hF0) && ((r_state == c_ST_IDLE) || (r_state == c_ST_EXT)));
    assign w_lookup = r_byte_stb && !w_prefix;

    always_comb begin
        w_code = 3'd0;
        if (w_is_ext) begin
            case (r_byte)
                8'h75:   w_code = 3'd1;
                8'h72:   w_code = 3'd2;
                8'h6B:   w_code = 3'd3;
                8'h74:   w_code = 3'd4;
                default: w_code = 3'd0;
            endcase
        end else begin
            case (r_byte)
                8'h1D:   w_code = 3'd1;
                8'h1B:   w_code = 3'd2;
                8'h1C:   w_code = 3'd3;
                8'h23:   w_code = 3'd4;
                8'h5A:   w_code = 3'd5;
                8'h76:   w_code = 3'd6;
                8'h29:   w_code = 3'd7;
                default: w_code = 3'd0;
            endcase
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    // Held-key mask indexed by op code; bit 0 is never set
    logic [7:0] r_held;

    assign w_accept = w_is_brk | ~r_held[w_code];

    always_ff @(posedge clk_100mhz or negedge rst) begin
        if (!rst) begin
            r_held <= 8'd0;
        end else if (w_lookup && (w_code != 3'd0)) begin
            r_held[w_code] <= ~w_is_brk;
        end
    end
`else
    assign w_accept = 1'b1;
`endif

    always_ff @(posedge clk_100mhz or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_push      <= 1'b0;
            r_push_brk  <= 1'b0;
            r_push_code <= 3'd0;
        end else begin
            r_push <= 1'b0;
            if (r_bad_frame) begin
                r_state <= c_ST_IDLE;
            end else if (r_byte_stb) begin
                if (r_byte == 8'hE0 && r_state == c_ST_IDLE) begin
                    r_state <= c_ST_EXT;
                end else if (r_byte == 8'hF0 && r_state == c_ST_IDLE) begin
                    r_state <= c_ST_BRK;
                end else if (r_byte == 8'hF0 && r_state == c_ST_EXT) begin
                    r_state <= c_ST_EXT_BRK;
                end else begin
                    r_state <= c_ST_IDLE;
                    if (w_code != 3'd0 && w_accept) begin
                        r_push      <= 1'b1;
                        r_push_code <= w_code;
                        r_push_brk  <= w_is_brk;
                    end
                end
            end
        end
    end

    // ---------------- event FIFO ----------------
    logic [OP_W:0]   r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;
    logic            w_full, w_pop, w_wr;
    logic [OP_W:0]   w_head;

    assign w_full = (r_count == c_DEPTH_CNT);
    assign w_pop  = op_valid & op_ready;
    // A pop in the same cycle frees the slot for a push at full
    assign w_wr   = r_push & (~w_full | w_pop);

    always_ff @(posedge clk_100mhz or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_push & w_full & ~w_pop;
            if (w_wr) begin
                r_mem[r_wr_ptr] <= {r_push_brk, OP_W'(r_push_code)};
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            if (w_wr && !w_pop)      r_count <= r_count + (c_AW + 1)'(1);
            else if (!w_wr && w_pop) r_count <= r_count - (c_AW + 1)'(1);
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign op_valid   = (r_count != '0);
    assign op_data    = w_head[OP_W-1:0];
    assign op_brk     = w_head[OP_W];
    assign fifo_count = r_count;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_cmd_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_cmd_queue
// Description : Directed bench for ps2_cmd_queue with a queue-based event model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_cmd_queue;

    localparam int CLK_HZ     = 1000000;
    localparam int FILT_LEN   = 4;
    localparam int TIMEOUT_US = 200;
    localparam int DEPTH      = 4;
    localparam int OP_W       = 5;
    localparam int H          = 20;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ps2_clk, ps2_data;
    logic                   op_valid, op_brk, op_ready;
    logic [OP_W-1:0]        op_data;
    logic                   frame_err, overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    ps2_cmd_queue #(
        .CLK_HZ(CLK_HZ), .FILT_LEN(FILT_LEN), .TIMEOUT_US(TIMEOUT_US),
        .DEPTH(DEPTH), .OP_W(OP_W)
    ) dut (
        .clk_100mhz(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .op_valid(op_valid), .op_data(op_data), .op_brk(op_brk), .op_ready(op_ready),
        .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { bit ext; logic [7:0] b; int code; } map_t;
    map_t key_map [11] = '{
        '{1'b0, 8'h1D, 1}, '{1'b0, 8'h1B, 2}, '{1'b0, 8'h1C, 3}, '{1'b0, 8'h23, 4},
        '{1'b0, 8'h5A, 5}, '{1'b0, 8'h76, 6}, '{1'b0, 8'h29, 7},
        '{1'b1, 8'h75, 1}, '{1'b1, 8'h72, 2}, '{1'b1, 8'h6B, 3}, '{1'b1, 8'h74, 4}
    };

    bit  m_ext, m_brk;
    bit  m_held [8];
    int  exp_q [$];   // events the FIFO must deliver, encoded brk*32+code
    int  exp_drop;

    function automatic int lookup(input bit ext, input logic [7:0] b);
        for (int i = 0; i < 11; i++)
            if (key_map[i].ext == ext && key_map[i].b == b) return key_map[i].code;
        return 0;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; exp_drop = 0;
        for (int i = 0; i < 8; i++) m_held[i] = 0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok, input bit pop_planned);
        int  code;
        bit  brk;
        bit  keep;
        if (!ok) begin
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0 && !m_ext && !m_brk) begin
            m_ext = 1;
        end else if (b == 8'hF0 && !m_brk) begin
            m_brk = 1;
        end else begin
            code = lookup(m_ext, b);
            brk  = m_brk;
            m_ext = 0; m_brk = 0;
            if (code != 0) begin
                keep = 1;
`ifdef PS2_REPEAT_FILTER_EN
                if (!brk && m_held[code]) keep = 0;
                m_held[code] = !brk;
`endif
                if (keep) begin
                    if (exp_q.size() >= DEPTH && !pop_planned) exp_drop++;
                    else exp_q.push_back(brk * 32 + code);
                end
            end
        end
    endtask

    // ---------------- compare process ----------------
    int  n_pop = 0, n_ferr = 0, n_ovf = 0;
    int  last_ev = -1;
    bit  hold_prev = 0;
    int  prev_head = 0;

    initial begin : compare
        int e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (frame_err) n_ferr++;
                if (overflow)  n_ovf++;
                check("valid_vs_count", int'(op_valid), int'(fifo_count != 0));
                if (hold_prev)
                    check("head_stable", {op_valid, op_brk, op_data}, 64 + prev_head);
                if (op_valid && op_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL pop_event: unexpected event brk=%0d data=%0d, expected none",
                                 op_brk, op_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_event", {op_brk, op_data}, e);
                    end
                    n_pop++;
                    last_ev = {op_brk, op_data};
                end
                hold_prev = op_valid && !op_ready;
                prev_head = {op_brk, op_data};
            end else begin
                hold_prev = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst = 1'b0; op_ready = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_valid", op_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_data",  {op_brk, op_data, frame_err, overflow}, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // mode 1: latency check on an empty FIFO expecting (1,make); mode 2: one-cycle pop aligned with the push
    task automatic send_frame(input logic [7:0] b, input bit bad, input int mode);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) model_byte(b, !bad, mode == 2);
            for (int k = 0; k < H; k++) begin
                @(negedge clk);
                if (i == 10 && mode == 1 && k == 7) check("lat_not_yet", op_valid, 0);
                if (i == 10 && mode == 1 && k == 8) begin
                    check("lat_valid", op_valid, 1);
                    check("lat_head", {op_brk, op_data}, 1);
                end
                if (i == 10 && mode == 2 && k == 7) op_ready = 1'b1;
                if (i == 10 && mode == 2 && k == 8) op_ready = 1'b0;
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic drain();
        op_ready = 1'b1;
        repeat (DEPTH + 4) @(negedge clk);
        op_ready = 1'b0;
        @(negedge clk);
        check("drain_count", fifo_count, 0);
        check("drain_model_empty", exp_q.size(), 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin : stim
        int p0, f0, o0;
        logic [3:0] part;

        // 1: single make with consumer ready
        do_reset();
        op_ready = 1'b1;
        p0 = n_pop;
        send_frame(8'h1D, 0, 1);
        repeat (5) @(negedge clk);
        check("t1_count", fifo_count, 0);
        check("t1_pops", n_pop - p0, 1);
        check("t1_event", last_ev, 1);
        op_ready = 1'b0;

        // 2: extended break produces one event only
        do_reset();
        p0 = n_pop;
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        check("t2_no_prefix_event", fifo_count, 0);
        send_frame(8'h74, 0, 0);
        check("t2_count", fifo_count, 1);
        drain();
        check("t2_pops", n_pop - p0, 1);
        check("t2_event", last_ev, 32 + 4);

        // 3: parity error clears a pending break prefix
        do_reset();
        p0 = n_pop; f0 = n_ferr;
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1D, 1, 0);
        check("t3_ferr", n_ferr - f0, 1);
        check("t3_no_push", fifo_count, 0);
        send_frame(8'h1B, 0, 0);
        drain();
        check("t3_pops", n_pop - p0, 1);
        check("t3_event", last_ev, 2);

        // 4: overflow and simultaneous push/pop at full
        do_reset();
        p0 = n_pop; o0 = n_ovf;
        send_frame(8'h1D, 0, 0);
        send_frame(8'h1B, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h23, 0, 0);
        send_frame(8'h5A, 0, 0);
        check("t4_full", fifo_count, DEPTH);
        check("t4_ovf", n_ovf - o0, 1);
        check("t4_model_drop", exp_drop, 1);
        check("t4_head", {op_brk, op_data}, 1);
        send_frame(8'h76, 0, 2);
        check("t4_full_after_pushpop", fifo_count, DEPTH);
        check("t4_no_new_ovf", n_ovf - o0, 1);
        check("t4_one_pop", n_pop - p0, 1);
        drain();
        check("t4_pops", n_pop - p0, DEPTH + 1);
        check("t4_last", last_ev, 6);

        // 5: inter-bit timeout aborts a partial frame
        do_reset();
        p0 = n_pop; f0 = n_ferr;
        part = 4'b1010;   // start bit then three data bits
        for (int i = 0; i < 4; i++) begin
            ps2_data = part[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (TIMEOUT_US + 60) @(negedge clk);
        check("t5_timeout_ferr", n_ferr - f0, 1);
        check("t5_no_push", fifo_count, 0);
        send_frame(8'h5A, 0, 0);
        drain();
        check("t5_pops", n_pop - p0, 1);
        check("t5_event", last_ev, 5);

        // 6: typematic repeat sequence
        do_reset();
        p0 = n_pop;
        op_ready = 1'b1;
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        repeat (20) @(negedge clk);
        op_ready = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
        check("t6_pops", n_pop - p0, 3);
`else
        check("t6_pops", n_pop - p0, 5);
`endif
        check("t6_last", last_ev, 3);
        check("t6_model_empty", exp_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
